// File: rtl/aes_subshift_col_feeder.sv
// ============================================================================
// Module   : aes_subshift_col_feeder
// Brief    : AES SubBytes (one column per cycle) followed by a ShiftRows
//            column feeder for the MixColumns column calculator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_subshift_col_feeder_sbox #(
    parameter logic [7:0] POLYNOMIAL = 8'h1B
) (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [7:0] c_affine = 8'h63;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? POLYNOMIAL : 8'h00);
        end
        return p;
    endfunction

    // a^254 = a^-1 for a != 0, and maps 0 to 0 without a special case
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] w_inv;

    always_comb begin
        w_inv = gf_inv(din);
        dout  = w_inv
              ^ {w_inv[6:0], w_inv[7]}
              ^ {w_inv[5:0], w_inv[7:6]}
              ^ {w_inv[4:0], w_inv[7:5]}
              ^ {w_inv[3:0], w_inv[7:4]}
              ^ c_affine;
    end
endmodule

module aes_subshift_col_feeder #(
    parameter bit         ENABLE_SUB   = 1'b1,
    parameter bit         ENABLE_SHIFT = 1'b1,
    parameter logic [7:0] POLYNOMIAL   = 8'h1B
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_s0,
    output logic [7:0]   out_s1,
    output logic [7:0]   out_s2,
    output logic [7:0]   out_s3,
    output logic [1:0]   out_col_idx,
    output logic         out_last_col,
    output logic         out_last_round
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t     r_fsm;
    state_t     w_fsm_next;
    logic [7:0] r_bytes [16];
    logic [1:0] r_col_cnt;
    logic       r_last_round;

    logic       w_load;
    logic       w_sub_en;
    logic       w_send_adv;
    logic [7:0] w_sub_in  [4];
    logic [7:0] w_sub_out [4];
    logic [7:0] w_out_byte [4];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= IDLE;
        else        r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        w_load     = 1'b0;
        w_sub_en   = 1'b0;
        w_send_adv = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load     = 1'b1;
                    w_fsm_next = SUB;
                end
            end
            SUB: begin
                w_sub_en = 1'b1;
                if (r_col_cnt == 2'd3) w_fsm_next = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_send_adv = 1'b1;
                    if (r_col_cnt == 2'd3) w_fsm_next = IDLE;
                end
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State storage: bytes are updated in place, column by column
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) r_bytes[k] <= 8'h00;
            r_col_cnt    <= 2'd0;
            r_last_round <= 1'b0;
        end else if (w_load) begin
            for (int k = 0; k < 16; k++) r_bytes[k] <= in_state[127 - 8*k -: 8];
            r_col_cnt    <= 2'd0;
            r_last_round <= in_last_round;
        end else if (w_sub_en) begin
            for (int r = 0; r < 4; r++) r_bytes[{r_col_cnt, 2'(r)}] <= w_sub_out[r];
            r_col_cnt <= r_col_cnt + 2'd1;
        end else if (w_send_adv) begin
            r_col_cnt <= r_col_cnt + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Per-row S-box lane and ShiftRows output selection
    // ------------------------------------------------------------------
    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam logic [1:0] c_row = 2'(r);
        logic [1:0] w_src_col;

        assign w_sub_in[r] = r_bytes[{r_col_cnt, c_row}];

        if (ENABLE_SUB) begin : g_sub
            aes_subshift_col_feeder_sbox #(
                .POLYNOMIAL(POLYNOMIAL)
            ) u_sbox (
                .din  (w_sub_in[r]),
                .dout (w_sub_out[r])
            );
        end else begin : g_bypass
            assign w_sub_out[r] = w_sub_in[r];
        end

        // Row r is rotated left by r columns; the 2-bit add wraps mod 4
        if (ENABLE_SHIFT) begin : g_shift
            assign w_src_col = r_col_cnt + c_row;
        end else begin : g_noshift
            assign w_src_col = r_col_cnt;
        end

        assign w_out_byte[r] = out_valid ? r_bytes[{w_src_col, c_row}] : 8'h00;
    end

    assign out_s0         = w_out_byte[0];
    assign out_s1         = w_out_byte[1];
    assign out_s2         = w_out_byte[2];
    assign out_s3         = w_out_byte[3];
    assign out_col_idx    = out_valid ? r_col_cnt : 2'd0;
    assign out_last_col   = out_valid && (r_col_cnt == 2'd3);
    assign out_last_round = out_valid && r_last_round;
endmodule

`default_nettype wire

// File: tb/tb_aes_subshift_col_feeder.sv
// ============================================================================
// Module   : tb_aes_subshift_col_feeder
// Brief    : Directed self-checking bench for aes_subshift_col_feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_subshift_col_feeder;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_state;
    logic         in_last_round;
    logic         out_ready;

    logic         in_ready, out_valid, out_last_col, out_last_round;
    logic [7:0]   out_s0, out_s1, out_s2, out_s3;
    logic [1:0]   out_col_idx;

    logic         nb_in_ready, nb_out_valid, nb_out_last_col, nb_out_last_round;
    logic [7:0]   nb_s0, nb_s1, nb_s2, nb_s3;
    logic [1:0]   nb_col_idx;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [127:0] c_fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] c_fips_out = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

    always #5 clk = ~clk;

    aes_subshift_col_feeder u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_last_round(in_last_round),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s0(out_s0), .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3),
        .out_col_idx(out_col_idx), .out_last_col(out_last_col),
        .out_last_round(out_last_round)
    );

    // Bypass-S-box instance runs in lockstep on the same inputs
    aes_subshift_col_feeder #(.ENABLE_SUB(1'b0)) u_dut_nosub (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(nb_in_ready),
        .in_state(in_state), .in_last_round(in_last_round),
        .out_valid(nb_out_valid), .out_ready(out_ready),
        .out_s0(nb_s0), .out_s1(nb_s1), .out_s2(nb_s2), .out_s3(nb_s3),
        .out_col_idx(nb_col_idx), .out_last_col(nb_out_last_col),
        .out_last_round(nb_out_last_round)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    task automatic push(input logic [127:0] st, input logic last);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", {31'd0, in_ready}, 32'd1);
        in_state      = st;
        in_last_round = last;
        in_valid      = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        check("valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    // Entered on the negedge where column 0 is presented; out_ready held high
    task automatic expect_cols(input string tag, input logic [127:0] exp,
                               input logic lr, input bit nosub);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (nosub)
                check($sformatf("%s_col%0d", tag, c), {nb_s0, nb_s1, nb_s2, nb_s3},
                      exp[127 - 32*c -: 32]);
            else
                check($sformatf("%s_col%0d", tag, c), {out_s0, out_s1, out_s2, out_s3},
                      exp[127 - 32*c -: 32]);
            check($sformatf("%s_idx%0d", tag, c), {30'd0, out_col_idx}, c);
            check($sformatf("%s_last_col%0d", tag, c), {31'd0, out_last_col},
                  (c == 3) ? 32'd1 : 32'd0);
            check($sformatf("%s_last_round%0d", tag, c), {31'd0, out_last_round}, {31'd0, lr});
        end
        @(negedge clk);
        check($sformatf("%s_done_valid", tag), {31'd0, out_valid}, 32'd0);
        check($sformatf("%s_done_ready", tag), {31'd0, in_ready}, 32'd1);
        check($sformatf("%s_idle_last_round", tag), {31'd0, out_last_round}, 32'd0);
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_state      = '0;
        in_last_round = 1'b0;
        out_ready     = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {out_s0, out_s1, out_s2, out_s3}, 32'd0);
        check("rst_flags", {29'd0, out_col_idx, out_last_col}, 32'd0);
        rst_n = 1'b1;

        // FIPS-197 round 1, latency and chaining into MixColumns
        push(c_fips_in, 1'b0);
        wait_valid(n);
        check("latency", n, 32'd5);
        check("mixcol0", mixcol({out_s0, out_s1, out_s2, out_s3}), 32'h046681e5);
        expect_cols("fips", c_fips_out, 1'b0, 1'b0);

        // S-box edge values and bypass
        push('0, 1'b0);
        wait_valid(n);
        expect_cols("zero", {4{32'h63636363}}, 1'b0, 1'b0);
        push({16{8'h53}}, 1'b0);
        wait_valid(n);
        expect_cols("x53", {16{8'hed}}, 1'b0, 1'b0);
        push(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
        wait_valid(n);
        expect_cols("nosub", 128'h00050a0f_04090e03_080d0207_0c01060b, 1'b0, 1'b1);

        // Backpressure on column 1 with ignored input pulses
        push(c_fips_in, 1'b0);
        wait_valid(n);
        check("bp_col0", {out_s0, out_s1, out_s2, out_s3}, 32'hd4bf5d30);
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_state = {4{$urandom}};
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {out_s0, out_s1, out_s2, out_s3}, 32'he0b452ae);
            check($sformatf("bp_hold_idx%0d", i), {30'd0, out_col_idx}, 32'd1);
            check($sformatf("bp_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("bp_col2", {out_s0, out_s1, out_s2, out_s3}, 32'hb84111f1);
        check("bp_idx2", {30'd0, out_col_idx}, 32'd2);
        @(negedge clk);
        check("bp_col3", {out_s0, out_s1, out_s2, out_s3}, 32'h1e2798e5);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_idle%0d", i), {30'd0, out_valid, in_ready}, 32'd1);
            @(negedge clk);
        end

        // Reset mid-SEND after column 1 is accepted
        push(c_fips_in, 1'b0);
        wait_valid(n);
        @(negedge clk);
        @(negedge clk);
        check("mid_pre_idx", {30'd0, out_col_idx}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", {out_s0, out_s1, out_s2, out_s3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rel_valid", {31'd0, out_valid}, 32'd0);
        push(c_fips_in, 1'b0);
        wait_valid(n);
        check("mid_latency", n, 32'd5);
        expect_cols("after_rst", c_fips_out, 1'b0, 1'b0);

        // Last-round flag pass-through
        push(c_fips_in, 1'b1);
        wait_valid(n);
        expect_cols("flag1", c_fips_out, 1'b1, 1'b0);
        push(c_fips_in, 1'b0);
        wait_valid(n);
        expect_cols("flag0", c_fips_out, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

`default_nettype wire
